send_scheduler: RTL and testbench
=================================

Name: send_scheduler

Overview:
- Sits between game logic, the Receiver's ACK path and the single Sender.
- Arbitrates four packet requesters (receiver ACK, game lost, ready, game data) onto the one Sender.
- Runs stop-and-wait reliability for non-ACK packets: 1-bit sequence number, timeout, bounded retransmission, sticky link_error.
- Sender is started by a one-cycle send_start pulse and completes with send_done.

Parameters:
TIMEOUT_CYCLES, 50000, cycles spent in WAIT_ACK before retransmit (1 ms at 50 MHz)
MAX_RETRIES, 3, retransmissions allowed per packet before giving up
RETRY_W, $clog2(MAX_RETRIES+1), width of retry_count

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
game_active  in  1  game running; gates data requests
req_data  in  1  level/pulse: new local game state to send
req_ready  in  1  request to send READY packet
req_lost  in  1  request to send GAME_LOST packet
req_ack  in  1  Receiver got a packet needing ACK
req_ack_seqNum  in  1  seqNum to echo in that ACK
ack_received  in  1  pulse: ACK packet arrived from opponent
ack_seqNum  in  1  seqNum carried by arrived ACK
send_done  in  1  pulse: Sender finished current packet
send_start  out  1  one-cycle pulse launching Sender
send_type  out  2  0 DATA, 1 READY, 2 LOST, 3 ACK; valid while busy
send_seqNum  out  1  seqNum for packet being sent
busy  out  1  state != IDLE
retry_count  out  RETRY_W  retransmissions of current packet
link_error  out  1  sticky: packet abandoned after MAX_RETRIES

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; tx_seq 0; all pending flags clear; timer 0. link_error is cleared only by rst.
- Pending flags pend_data, pend_ready, pend_lost, pend_ack:
  - Each is set in any cycle its req is high.
  - Each is cleared in the cycle its packet is launched.
  - Set and launch in the same cycle: flag stays set.
  - pend_ack stores req_ack_seqNum; a newer req_ack overwrites it.
- game_active=0: req_data is ignored and pend_data is forced clear. Other requests are unaffected.
- Priority at launch: ACK > LOST > READY > DATA.
- IDLE:
  - If any flag is pending, pulse send_start and set send_type to the winner.
  - send_seqNum = stored ack seq for ACK, otherwise tx_seq.
  - Clear the winning flag, set retry_count=0, go WAIT_DONE.
  - send_start is combinationally tied to this transition: it rises in the cycle after the request is registered.
- WAIT_DONE: hold send_type and send_seqNum. On send_done:
  - ACK launched from IDLE: go IDLE.
  - ACK interleaved from WAIT_ACK: restore the saved type/seq and go WAIT_ACK with the timer unchanged.
  - Otherwise: go WAIT_ACK with timer=0.
- WAIT_ACK (priority order):
  1. ack_received && ack_seqNum==tx_seq: toggle tx_seq, go IDLE. A mismatched ack is ignored.
  2. Else if pend_ack: save current type/seq, freeze timer, launch ACK (send_start pulse), go WAIT_DONE flagged interleaved. This prevents mutual deadlock.
  3. Else if timer==TIMEOUT_CYCLES-1:
     - retry_count<MAX_RETRIES: retry_count++, relaunch same type and tx_seq (send_start pulse), go WAIT_DONE.
     - Otherwise: set link_error, toggle tx_seq, go IDLE. The packet is dropped.
  4. Else timer++.
- A DATA retransmit resends the Sender's current playfield snapshot. A DATA request arriving meanwhile stays pending and is sent after the ack.
- ack_received outside WAIT_ACK is ignored.
- send_done outside WAIT_DONE is ignored.
- send_start never asserts in two consecutive cycles. At most one packet is outstanding.

Test Plan:
(TIMEOUT_CYCLES=8, MAX_RETRIES=2 for sim)
1. Reset, game_active=1, pulse req_data -> next cycle send_start=1, send_type=0, send_seqNum=0. send_done 5 cycles later -> WAIT_ACK. ack_received with ack_seqNum=0 -> busy=0, next data sent with seqNum=1.
2. req_data, req_ready, req_lost, req_ack(seq 1) all in the same cycle -> launch order ACK(seq 1), LOST, READY, DATA. Each non-ACK waits for its matching ack.
3. DATA sent, no ack -> resend every 8 cycles after send_done, retry_count 1 then 2. After the third timeout, link_error=1 and busy=0.
4. In WAIT_ACK, ack arrives with ack_seqNum=1 while tx_seq=0 -> ignored, retransmit at timeout. Then ack seq 0 -> IDLE.
5. In WAIT_ACK at timer=3, req_ack(seq 0) -> ACK sent. After send_done, back in WAIT_ACK with DATA/seq restored; timeout fires 5 cycles later (timer resumes from 3).
6. game_active=0, pulse req_data -> no send_start. Assert rst mid-WAIT_DONE -> all outputs 0 immediately, link_error cleared.

Source files
------------

// File: rtl/send_scheduler.sv
// send_scheduler
//   Arbitrates the four packet requesters (receiver ACK, game lost, ready,
//   game data) onto the single Sender. It also runs stop-and-wait reliability
//   for every non-ACK packet: a 1-bit sequence number, a timeout and bounded
//   retransmission. When a packet is finally abandoned, link_error is set and
//   stays set.
//
// Ports
//   clk, rst           system clock, asynchronous active-high reset
//   game_active        game running; gates data requests
//   req_data           new local game state to send
//   req_ready          send a READY packet
//   req_lost           send a GAME_LOST packet
//   req_ack            Receiver needs an ACK sent
//   req_ack_seqNum     sequence number to echo in that ACK
//   ack_received       ACK arrived from the opponent
//   ack_seqNum         sequence number carried by that ACK
//   send_done          Sender finished the current packet
//   send_start         one-cycle pulse launching the Sender
//   send_type          0 DATA, 1 READY, 2 LOST, 3 ACK
//   send_seqNum        sequence number of the packet being sent
//   busy               scheduler not idle
//   retry_count        retransmissions of the current packet
//   link_error         sticky: a packet was abandoned
module send_scheduler #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES    = 3,
  parameter int RETRY_W        = $clog2(MAX_RETRIES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_active,
  input  logic               req_data,
  input  logic               req_ready,
  input  logic               req_lost,
  input  logic               req_ack,
  input  logic               req_ack_seqNum,
  input  logic               ack_received,
  input  logic               ack_seqNum,
  input  logic               send_done,
  output logic               send_start,
  output logic [1:0]         send_type,
  output logic               send_seqNum,
  output logic               busy,
  output logic [RETRY_W-1:0] retry_count,
  output logic               link_error
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

  localparam logic [1:0] TYPE_DATA  = 2'd0;
  localparam logic [1:0] TYPE_READY = 2'd1;
  localparam logic [1:0] TYPE_LOST  = 2'd2;
  localparam logic [1:0] TYPE_ACK   = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    WAIT_ACK  = 2'd2
  } state_t;

  // Fixed launch priority: ACK > LOST > READY > DATA.
  function automatic logic [1:0] pick_winner(input logic ack, input logic lost,
                                             input logic ready);
    logic [1:0] w;
    if (ack) begin
      w = TYPE_ACK;
    end else if (lost) begin
      w = TYPE_LOST;
    end else if (ready) begin
      w = TYPE_READY;
    end else begin
      w = TYPE_DATA;
    end
    return w;
  endfunction

  state_t               state_r, state_nx;
  logic [1:0]           type_r, type_nx;
  logic                 seq_r, seq_nx;
  logic [1:0]           save_type_r, save_type_nx;
  logic                 interleaved_r, interleaved_nx;
  logic                 tx_seq_r, tx_seq_nx;
  logic [TIMER_W-1:0]   timer_r, timer_nx;
  logic [RETRY_W-1:0]   retry_r, retry_nx;
  logic                 link_error_r, link_error_nx;
  logic                 pend_data_r, pend_data_nx;
  logic                 pend_ready_r, pend_ready_nx;
  logic                 pend_lost_r, pend_lost_nx;
  logic                 pend_ack_r, pend_ack_nx;
  logic                 pend_ack_seq_r, pend_ack_seq_nx;

  logic                 start_s;
  logic [1:0]           start_type_s;
  logic                 start_seq_s;
  logic                 data_ok_s;
  logic                 any_pend_s;
  logic                 launch_data_s, launch_ready_s, launch_lost_s, launch_ack_s;

  // Next-state, launch decisions and pending-flag bookkeeping.
  always_comb begin
    state_nx        = state_r;
    type_nx         = type_r;
    seq_nx          = seq_r;
    save_type_nx    = save_type_r;
    interleaved_nx  = interleaved_r;
    tx_seq_nx       = tx_seq_r;
    timer_nx        = timer_r;
    retry_nx        = retry_r;
    link_error_nx   = link_error_r;
    start_s         = 1'b0;
    start_type_s    = type_r;
    start_seq_s     = seq_r;
    launch_data_s   = 1'b0;
    launch_ready_s  = 1'b0;
    launch_lost_s   = 1'b0;
    launch_ack_s    = 1'b0;

    // A stale data flag must never launch once the game has stopped.
    data_ok_s  = pend_data_r & game_active;
    any_pend_s = pend_ack_r | pend_lost_r | pend_ready_r | data_ok_s;

    case (state_r)
      IDLE: begin
        if (any_pend_s) begin
          start_s        = 1'b1;
          start_type_s   = pick_winner(pend_ack_r, pend_lost_r, pend_ready_r);
          start_seq_s    = pend_ack_r ? pend_ack_seq_r : tx_seq_r;
          launch_ack_s   = pend_ack_r;
          launch_lost_s  = !pend_ack_r && pend_lost_r;
          launch_ready_s = !pend_ack_r && !pend_lost_r && pend_ready_r;
          launch_data_s  = !pend_ack_r && !pend_lost_r && !pend_ready_r;
          type_nx        = start_type_s;
          seq_nx         = start_seq_s;
          retry_nx       = {RETRY_W{1'b0}};
          interleaved_nx = 1'b0;
          state_nx       = WAIT_DONE;
        end else begin
          state_nx = IDLE;
        end
      end

      WAIT_DONE: begin
        if (send_done) begin
          if (interleaved_r) begin
            // Resume waiting for the outstanding packet; timer stays frozen.
            type_nx        = save_type_r;
            seq_nx         = tx_seq_r;
            interleaved_nx = 1'b0;
            state_nx       = WAIT_ACK;
          end else if (type_r == TYPE_ACK) begin
            state_nx = IDLE;
          end else begin
            timer_nx = {TIMER_W{1'b0}};
            state_nx = WAIT_ACK;
          end
        end else begin
          state_nx = WAIT_DONE;
        end
      end

      WAIT_ACK: begin
        if (ack_received && (ack_seqNum == tx_seq_r)) begin
          tx_seq_nx = ~tx_seq_r;
          state_nx  = IDLE;
        end else if (pend_ack_r) begin
          // Answer the peer now, or two stalled peers would wait on each other.
          start_s        = 1'b1;
          start_type_s   = TYPE_ACK;
          start_seq_s    = pend_ack_seq_r;
          launch_ack_s   = 1'b1;
          save_type_nx   = type_r;
          type_nx        = TYPE_ACK;
          seq_nx         = pend_ack_seq_r;
          interleaved_nx = 1'b1;
          state_nx       = WAIT_DONE;
        end else if (timer_r == TIMER_LAST) begin
          if (retry_r < RETRY_MAX) begin
            retry_nx     = retry_r + RETRY_W'(1);
            start_s      = 1'b1;
            start_type_s = type_r;
            start_seq_s  = tx_seq_r;
            seq_nx       = tx_seq_r;
            state_nx     = WAIT_DONE;
          end else begin
            // Give up: drop the packet and move to the next sequence number.
            link_error_nx = 1'b1;
            tx_seq_nx     = ~tx_seq_r;
            state_nx      = IDLE;
          end
        end else begin
          timer_nx = timer_r + TIMER_W'(1);
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    // A request in the launch cycle re-arms its flag.
    pend_ack_nx     = req_ack | (pend_ack_r & ~launch_ack_s);
    pend_lost_nx    = req_lost | (pend_lost_r & ~launch_lost_s);
    pend_ready_nx   = req_ready | (pend_ready_r & ~launch_ready_s);
    pend_data_nx    = game_active & (req_data | (pend_data_r & ~launch_data_s));
    pend_ack_seq_nx = req_ack ? req_ack_seqNum : pend_ack_seq_r;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      type_r         <= TYPE_DATA;
      seq_r          <= 1'b0;
      save_type_r    <= TYPE_DATA;
      interleaved_r  <= 1'b0;
      tx_seq_r       <= 1'b0;
      timer_r        <= {TIMER_W{1'b0}};
      retry_r        <= {RETRY_W{1'b0}};
      link_error_r   <= 1'b0;
      pend_data_r    <= 1'b0;
      pend_ready_r   <= 1'b0;
      pend_lost_r    <= 1'b0;
      pend_ack_r     <= 1'b0;
      pend_ack_seq_r <= 1'b0;
    end else begin
      state_r        <= state_nx;
      type_r         <= type_nx;
      seq_r          <= seq_nx;
      save_type_r    <= save_type_nx;
      interleaved_r  <= interleaved_nx;
      tx_seq_r       <= tx_seq_nx;
      timer_r        <= timer_nx;
      retry_r        <= retry_nx;
      link_error_r   <= link_error_nx;
      pend_data_r    <= pend_data_nx;
      pend_ready_r   <= pend_ready_nx;
      pend_lost_r    <= pend_lost_nx;
      pend_ack_r     <= pend_ack_nx;
      pend_ack_seq_r <= pend_ack_seq_nx;
    end
  end

  // The Sender samples type/seq together with send_start, so the launch value
  // is presented in the launch cycle and the registered value afterwards.
  assign send_start  = start_s;
  assign send_type   = start_s ? start_type_s : type_r;
  assign send_seqNum = start_s ? start_seq_s : seq_r;
  assign busy        = (state_r != IDLE);
  assign retry_count = retry_r;
  assign link_error  = link_error_r;

endmodule

// File: tb/tb_send_scheduler.sv
// tb_send_scheduler
//   Directed bench for send_scheduler with TIMEOUT_CYCLES=8, MAX_RETRIES=2.
//   Inputs change just after the falling edge; outputs are sampled 1 ns later,
//   well before the next rising edge.
module tb_send_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       game_active;
  logic       req_data, req_ready, req_lost, req_ack, req_ack_seqNum;
  logic       ack_received, ack_seqNum, send_done;
  logic       send_start;
  logic [1:0] send_type;
  logic       send_seqNum;
  logic       busy;
  logic [1:0] retry_count;
  logic       link_error;

  int checks   = 0;
  int failures = 0;

  send_scheduler #(
    .TIMEOUT_CYCLES(8),
    .MAX_RETRIES   (2),
    .RETRY_W       (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .game_active   (game_active),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .req_lost      (req_lost),
    .req_ack       (req_ack),
    .req_ack_seqNum(req_ack_seqNum),
    .ack_received  (ack_received),
    .ack_seqNum    (ack_seqNum),
    .send_done     (send_done),
    .send_start    (send_start),
    .send_type     (send_type),
    .send_seqNum   (send_seqNum),
    .busy          (busy),
    .retry_count   (retry_count),
    .link_error    (link_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_launch(input string tag, input logic [1:0] typ, input logic seq);
    chk({tag, "_start"}, {31'd0, send_start}, 32'd1);
    chk({tag, "_type"}, {30'd0, send_type}, {30'd0, typ});
    chk({tag, "_seq"}, {31'd0, send_seqNum}, {31'd0, seq});
  endtask

  // Advance to the next falling edge and drop all pulse inputs.
  task automatic tick();
    @(negedge clk);
    req_data     = 1'b0;
    req_ready    = 1'b0;
    req_lost     = 1'b0;
    req_ack      = 1'b0;
    ack_received = 1'b0;
    send_done    = 1'b0;
  endtask

  // n cycles in which no launch may happen.
  task automatic quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      #1;
      chk(tag, {31'd0, send_start}, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; game_active = 1'b0;
    req_data = 1'b0; req_ready = 1'b0; req_lost = 1'b0; req_ack = 1'b0;
    req_ack_seqNum = 1'b0; ack_received = 1'b0; ack_seqNum = 1'b0; send_done = 1'b0;
    #1;
    chk("rst_start", {31'd0, send_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_type", {30'd0, send_type}, 32'd0);
    chk("rst_seq", {31'd0, send_seqNum}, 32'd0);
    chk("rst_retry", {30'd0, retry_count}, 32'd0);
    chk("rst_lerr", {31'd0, link_error}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: single DATA, then a second DATA with the toggled sequence number.
    tick(); game_active = 1'b1; req_data = 1'b1; #1;
    chk("t1_no_start_yet", {31'd0, send_start}, 32'd0);
    tick(); #1;
    chk_launch("t1_launch", 2'd0, 1'b0);
    chk("t1_busy_at_launch", {31'd0, busy}, 32'd0);
    tick(); #1;
    chk("t1_pulse_width", {31'd0, send_start}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_hold_type", {30'd0, send_type}, 32'd0);
    repeat (3) tick();
    tick(); send_done = 1'b1; #1;
    tick(); ack_received = 1'b1; ack_seqNum = 1'b0; #1;
    chk("t1_wait_ack_busy", {31'd0, busy}, 32'd1);
    tick(); #1;
    chk("t1_idle", {31'd0, busy}, 32'd0);
    req_data = 1'b1;
    tick(); #1;
    chk_launch("t1_second", 2'd0, 1'b1);
    tick(); send_done = 1'b1; #1;
    tick(); ack_received = 1'b1; ack_seqNum = 1'b1; #1;
    tick(); #1;
    chk("t1_done_idle", {31'd0, busy}, 32'd0);

    // 2: all four requests at once -> ACK, LOST, READY, DATA.
    tick(); req_data = 1'b1; req_ready = 1'b1; req_lost = 1'b1;
    req_ack = 1'b1; req_ack_seqNum = 1'b1; #1;
    tick(); #1;
    chk_launch("t2_ack", 2'd3, 1'b1);
    tick(); send_done = 1'b1; #1;
    chk("t2_ack_busy", {31'd0, busy}, 32'd1);
    tick(); #1;
    chk("t2_ack_back_idle", {31'd0, busy}, 32'd0);
    chk_launch("t2_lost", 2'd2, 1'b0);
    tick(); send_done = 1'b1; #1;
    tick(); ack_received = 1'b1; ack_seqNum = 1'b0; #1;
    tick(); #1;
    chk_launch("t2_ready", 2'd1, 1'b1);
    tick(); send_done = 1'b1; #1;
    tick(); ack_received = 1'b1; ack_seqNum = 1'b1; #1;
    tick(); #1;
    chk_launch("t2_data", 2'd0, 1'b0);
    tick(); send_done = 1'b1; #1;
    tick(); ack_received = 1'b1; ack_seqNum = 1'b0; #1;
    tick(); #1;
    chk("t2_idle", {31'd0, busy}, 32'd0);
    chk("t2_no_start", {31'd0, send_start}, 32'd0);

    // 3: no ack at all -> two retransmits, then link_error.
    tick(); req_data = 1'b1; #1;
    tick(); #1;
    chk_launch("t3_first", 2'd0, 1'b1);
    chk("t3_retry0", {30'd0, retry_count}, 32'd0);
    tick(); send_done = 1'b1; #1;
    quiet(7, "t3_no_early1");
    tick(); #1;
    chk_launch("t3_retx1", 2'd0, 1'b1);
    tick(); send_done = 1'b1; #1;
    chk("t3_retry1", {30'd0, retry_count}, 32'd1);
    quiet(7, "t3_no_early2");
    tick(); #1;
    chk_launch("t3_retx2", 2'd0, 1'b1);
    tick(); send_done = 1'b1; #1;
    chk("t3_retry2", {30'd0, retry_count}, 32'd2);
    chk("t3_lerr_before", {31'd0, link_error}, 32'd0);
    quiet(7, "t3_no_early3");
    tick(); #1;
    chk("t3_giveup_no_start", {31'd0, send_start}, 32'd0);
    chk("t3_busy_at_giveup", {31'd0, busy}, 32'd1);
    tick(); #1;
    chk("t3_lerr", {31'd0, link_error}, 32'd1);
    chk("t3_busy_off", {31'd0, busy}, 32'd0);

    // 4: mismatched ack ignored, retransmit at timeout, matching ack ends it.
    tick(); req_data = 1'b1; #1;
    tick(); #1;
    chk_launch("t4_first", 2'd0, 1'b0);
    tick(); send_done = 1'b1; #1;
    tick(); ack_received = 1'b1; ack_seqNum = 1'b1; #1;
    chk("t4_mismatch_busy", {31'd0, busy}, 32'd1);
    quiet(6, "t4_no_early");
    tick(); #1;
    chk_launch("t4_retx", 2'd0, 1'b0);
    tick(); send_done = 1'b1; #1;
    tick(); ack_received = 1'b1; ack_seqNum = 1'b0; #1;
    tick(); #1;
    chk("t4_idle", {31'd0, busy}, 32'd0);
    chk("t4_lerr_sticky", {31'd0, link_error}, 32'd1);

    // 5: ACK interleaved at timer=3; timer resumes from 3 afterwards.
    tick(); req_data = 1'b1; #1;
    tick(); #1;
    chk_launch("t5_first", 2'd0, 1'b1);
    tick(); send_done = 1'b1; #1;
    tick(); #1;
    tick(); #1;
    tick(); req_ack = 1'b1; req_ack_seqNum = 1'b0; #1;
    chk("t5_t2_no_start", {31'd0, send_start}, 32'd0);
    tick(); #1;
    chk_launch("t5_ack", 2'd3, 1'b0);
    tick(); send_done = 1'b1; #1;
    chk("t5_ack_type_hold", {30'd0, send_type}, 32'd3);
    chk("t5_ack_seq_hold", {31'd0, send_seqNum}, 32'd0);
    tick(); #1;
    chk("t5_restored_type", {30'd0, send_type}, 32'd0);
    chk("t5_restored_seq", {31'd0, send_seqNum}, 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd1);
    chk("t5_t3_no_start", {31'd0, send_start}, 32'd0);
    quiet(3, "t5_no_early");
    tick(); #1;
    chk_launch("t5_timeout", 2'd0, 1'b1);
    chk("t5_retry_kept", {30'd0, retry_count}, 32'd0);
    tick(); send_done = 1'b1; #1;
    chk("t5_retry1", {30'd0, retry_count}, 32'd1);
    tick(); ack_received = 1'b1; ack_seqNum = 1'b1; #1;
    tick(); #1;
    chk("t5_idle", {31'd0, busy}, 32'd0);

    // 6: data gated while game inactive; async reset mid-WAIT_DONE.
    tick(); game_active = 1'b0; req_data = 1'b1; #1;
    tick(); #1;
    chk("t6_gated", {31'd0, send_start}, 32'd0);
    tick(); game_active = 1'b1; #1;
    chk("t6_flag_cleared", {31'd0, send_start}, 32'd0);
    chk("t6_gated_busy", {31'd0, busy}, 32'd0);
    tick(); req_ready = 1'b1; #1;
    tick(); #1;
    chk_launch("t6_ready", 2'd1, 1'b0);
    tick(); #1;
    chk("t6_wait_done_busy", {31'd0, busy}, 32'd1);
    chk("t6_wait_done_type", {30'd0, send_type}, 32'd1);
    rst = 1'b1; #1;
    chk("t6_rst_start", {31'd0, send_start}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_type", {30'd0, send_type}, 32'd0);
    chk("t6_rst_seq", {31'd0, send_seqNum}, 32'd0);
    chk("t6_rst_retry", {30'd0, retry_count}, 32'd0);
    chk("t6_rst_lerr", {31'd0, link_error}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(); req_data = 1'b1; #1;
    tick(); #1;
    chk_launch("t6_post_reset", 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
